adc_capture: RTL and testbench
==============================

ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter SCK_DIV, default 1, clk cycles per spisck half-period (legal range 1..15).
REQ-002 Parameter CONV_CYCLES, default 1, clk cycles ad_conv is held high (legal range 1..7).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  single-cycle request for one conversion frame.
REQ-006 amp_cs_n  input  1  preamp chip select; low means the shared SPI bus is owned by the preamp writer.
REQ-007 spimiso  input  1  ADC serial data.
REQ-008 spisck  output  1  SPI clock, registered.
REQ-009 ad_conv  output  1  ADC conversion strobe, registered.
REQ-010 sample_ch0  output  14  last channel-0 sample, two's complement.
REQ-011 sample_ch1  output  14  last channel-1 sample, two's complement.
REQ-012 sample_valid  output  1  one-cycle pulse when both samples update.
REQ-013 busy  output  1  high whenever state is not IDLE or a request is pending.
REQ-014 overrun  output  1  sticky error flag (see Configuration).

Function
REQ-015 States: IDLE, WAIT_BUS, CONV, SHIFT, DONE.
REQ-016 IDLE: start=1 and amp_cs_n=1 -> CONV; start=1 and amp_cs_n=0 -> WAIT_BUS; else stay.
REQ-017 WAIT_BUS: stay until amp_cs_n=1, then -> CONV.
REQ-018 CONV: ad_conv=1 for exactly CONV_CYCLES cycles, spisck=0, then -> SHIFT.
REQ-019 SHIFT: spisck toggles every SCK_DIV cycles, starting low, for exactly 34 full SCK periods (68*SCK_DIV cycles), then -> DONE with spisck=0.
REQ-020 spimiso sampled on the clk edge that drives spisck 1->0; bit index 0 = first sampled bit.
REQ-021 Frame mapping: bits 0-1 ignored, bits 2-15 = ch0 MSB first, bits 16-17 ignored, bits 18-31 = ch1 MSB first, bits 32-33 ignored.
REQ-022 DONE: sample_ch0/ch1 load from the shift register, sample_valid=1 for one cycle, -> IDLE; outputs hold until next DONE.
REQ-023 Latency (amp_cs_n=1): sample_valid high exactly 1+CONV_CYCLES+68*SCK_DIV cycles after the edge sampling start (70 at defaults).
REQ-024 start while not IDLE is ignored (no queueing).
REQ-025 amp_cs_n going low during CONV or SHIFT does not abort the frame.
REQ-026 start and sample_valid in the same cycle: new request accepted (DONE exits to IDLE first, so start in DONE is ignored per REQ-024).

Reset
REQ-027 On reset: state IDLE, spisck=0, ad_conv=0, sample_ch0=0, sample_ch1=0, sample_valid=0, busy=0, overrun=0, counters and shift register cleared.
REQ-028 Reset mid-frame abandons the frame with no sample_valid; next frame requires a fresh start.

Configuration
REQ-029 Macro ADC_OVERRUN_EN defined: start=1 while busy=1 sets overrun, cleared only by reset.
REQ-030 Macro ADC_OVERRUN_EN undefined: overrun tied to 0, no overrun logic synthesised.

Structure
REQ-031 Shared package adc_pkg holds state encoding, FRAME_BITS=34, SAMPLE_W=14, CH0_MSB_IDX=2, CH1_MSB_IDX=18.
REQ-032 One sub-module adc_sck_gen: divider producing spisck plus one-cycle rise/fall strobes, enabled only in SHIFT.

Verification
REQ-033 Defaults, amp_cs_n=1, start pulse, model drives ch0=14'h1FFF, ch1=14'h2000 -> sample_valid at start+70 cycles, sample_ch0=14'h1FFF, sample_ch1=14'h2000, exactly 34 spisck rising edges, ad_conv high 1 cycle.
REQ-034 amp_cs_n=0 for 20 cycles around start -> ad_conv only after amp_cs_n=1, busy=1 throughout wait, data correct.
REQ-035 SCK_DIV=3, CONV_CYCLES=4, ch0=14'h0001, ch1=14'h3FFF -> spisck period 6 cycles, sample_valid at start+209, values match.
REQ-036 Reset asserted at SHIFT bit 10 -> all outputs 0 next cycle, no sample_valid; following start produces correct frame.
REQ-037 Second start 5 cycles after first -> single frame only; with ADC_OVERRUN_EN overrun=1 and stays 1 until reset; without it overrun=0.
REQ-038 Model drives 1s on ignored bits 0,1,16,17,32,33 with zero samples -> sample_ch0=sample_ch1=0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture block: FSM encoding, frame layout
// constants and the helper that pulls one sample out of the shift register.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUS = 3'd1,
    CONV     = 3'd2,
    SHIFT    = 3'd3,
    DONE     = 3'd4
  } adc_state_e;

  localparam int FRAME_BITS  = 34;
  localparam int SAMPLE_W    = 14;
  localparam int CH0_MSB_IDX = 2;
  localparam int CH1_MSB_IDX = 18;
  localparam int BIT_CNT_W   = 6;

  // Frame bit k is shifted in k-th, so it ends up at position FRAME_BITS-1-k.
  function automatic logic [SAMPLE_W-1:0] extract_sample(
    input logic [FRAME_BITS-1:0] frame,
    input int                    msb_idx
  );
    return frame[FRAME_BITS-1-msb_idx -: SAMPLE_W];
  endfunction

endpackage

// File: rtl/adc_capture_if.sv
// Request/status and SPI pin bundle of adc_capture; master = capture block,
// slave = the requester/board side.
interface adc_capture_if;
  import adc_pkg::*;

  logic                start;
  logic                amp_cs_n;
  logic                spimiso;
  logic                spisck;
  logic                ad_conv;
  logic [SAMPLE_W-1:0] sample_ch0;
  logic [SAMPLE_W-1:0] sample_ch1;
  logic                sample_valid;
  logic                busy;
  logic                overrun;

  modport master (
    input  start, amp_cs_n, spimiso,
    output spisck, ad_conv, sample_ch0, sample_ch1, sample_valid, busy, overrun
  );

  modport slave (
    output start, amp_cs_n, spimiso,
    input  spisck, ad_conv, sample_ch0, sample_ch1, sample_valid, busy, overrun
  );
endinterface

// File: rtl/adc_sck_gen.sv
// SPI clock divider: spisck toggles every SCK_DIV clk cycles while enabled,
// parks low otherwise; rise/fall flag the cycle whose closing edge moves spisck.
module adc_sck_gen #(
  parameter int SCK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  logic [3:0] div_cnt_r;
  logic       sck_r;
  logic       tick_s;

  assign tick_s   = en && (div_cnt_r == 4'(SCK_DIV - 1));
  assign sck      = sck_r;
  assign sck_rise = tick_s & ~sck_r;
  assign sck_fall = tick_s & sck_r;

  // Half-period counter and registered SPI clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= 4'd0;
      sck_r     <= 1'b0;
    end else if (!en) begin
      div_cnt_r <= 4'd0;
      sck_r     <= 1'b0;
    end else if (tick_s) begin
      div_cnt_r <= 4'd0;
      sck_r     <= ~sck_r;
    end else begin
      div_cnt_r <= div_cnt_r + 4'd1;
      sck_r     <= sck_r;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// Dual-channel serial ADC frame capture sharing the SPI bus with a preamp writer.
// Optional sticky overrun detection is built when ADC_OVERRUN_EN is defined.
module adc_capture
  import adc_pkg::*;
#(
  parameter int SCK_DIV     = 1,
  parameter int CONV_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  adc_capture_if.master bus
);

  adc_state_e            state_r;
  logic [2:0]            conv_cnt_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic                  ad_conv_r;
  logic [SAMPLE_W-1:0]   ch0_r;
  logic [SAMPLE_W-1:0]   ch1_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  shift_en_s;
  logic                  sck_s;
  logic                  rise_s;
  logic                  fall_s;

  assign shift_en_s = (state_r == SHIFT);

  adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (shift_en_s),
    .sck      (sck_s),
    .sck_rise (rise_s),
    .sck_fall (fall_s)
  );

  // Frame sequencer; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      conv_cnt_r <= 3'd0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      ad_conv_r  <= 1'b0;
      ch0_r      <= '0;
      ch1_r      <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            busy_r     <= 1'b1;
            conv_cnt_r <= 3'd0;
            bit_cnt_r  <= '0;
            if (bus.amp_cs_n) begin
              state_r   <= CONV;
              ad_conv_r <= 1'b1;
            end else begin
              state_r   <= WAIT_BUS;
            end
          end
        end
        WAIT_BUS: begin
          if (bus.amp_cs_n) begin
            state_r   <= CONV;
            ad_conv_r <= 1'b1;
          end
        end
        CONV: begin
          if (conv_cnt_r == 3'(CONV_CYCLES - 1)) begin
            state_r   <= SHIFT;
            ad_conv_r <= 1'b0;
          end else begin
            conv_cnt_r <= conv_cnt_r + 3'd1;
          end
        end
        SHIFT: begin
          // Periods are counted on rises; the 34th fall both samples the last bit and ends the frame.
          if (rise_s) begin
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end
          if (fall_s) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], bus.spimiso};
            if (bit_cnt_r == 6'(FRAME_BITS)) begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          ch0_r   <= extract_sample(shift_r, CH0_MSB_IDX);
          ch1_r   <= extract_sample(shift_r, CH1_MSB_IDX);
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          ad_conv_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spisck       = sck_s;
  assign bus.ad_conv      = ad_conv_r;
  assign bus.sample_ch0   = ch0_r;
  assign bus.sample_ch1   = ch1_r;
  assign bus.sample_valid = valid_r;
  assign bus.busy         = busy_r;

`ifdef ADC_OVERRUN_EN
  logic overrun_r;

  // Sticky flag for any request that arrives while a frame is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (bus.start && busy_r) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign bus.overrun = overrun_r;
`else
  assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: two instances (default timing and SCK_DIV=3/CONV_CYCLES=4),
// a serial ADC model per instance and a scoreboard queue of expected frames.
module tb_adc_capture;

  typedef struct {
    logic [13:0] c0;
    logic [13:0] c1;
    int          cyc;
  } exp_t;

`ifdef ADC_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_capture_if bus_a ();
  adc_capture_if bus_b ();

  adc_capture #(.SCK_DIV(1), .CONV_CYCLES(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  adc_capture #(.SCK_DIV(3), .CONV_CYCLES(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea;
  exp_t        eb;
  logic [33:0] frm_a = '0;
  logic [33:0] frm_b = '0;
  int          idx_a = 0;
  int          idx_b = 0;
  int          rises_a = 0;
  int          rises_b = 0;
  int          conv_hi_a = 0;
  time         rise_last_b = 0;
  time         rise_prev_b = 0;
  logic        prev_va = 1'b0;
  logic        prev_vb = 1'b0;

  // Frame bit i is the i-th bit the ADC presents; samples go out MSB first.
  function automatic logic [33:0] mk_frame(input logic [13:0] c0, input logic [13:0] c1, input logic ign);
    logic [33:0] f;
    f = '0;
    for (int i = 0; i < 14; i++) begin
      f[2 + i]  = c0[13 - i];
      f[18 + i] = c1[13 - i];
    end
    f[0] = ign; f[1] = ign; f[16] = ign; f[17] = ign; f[32] = ign; f[33] = ign;
    return f;
  endfunction

  // Serial ADC models: present bit 0 at conversion, advance after every falling spisck.
  always @(posedge bus_a.ad_conv) begin idx_a = 0; bus_a.spimiso = frm_a[0]; end
  always @(negedge bus_a.spisck) begin idx_a++; if (idx_a < 34) bus_a.spimiso = frm_a[idx_a]; end
  always @(posedge bus_b.ad_conv) begin idx_b = 0; bus_b.spimiso = frm_b[0]; end
  always @(negedge bus_b.spisck) begin idx_b++; if (idx_b < 34) bus_b.spimiso = frm_b[idx_b]; end

  always @(posedge bus_a.spisck) rises_a++;
  always @(negedge clk) if (bus_a.ad_conv === 1'b1) conv_hi_a++;
  always @(posedge bus_b.spisck) begin rises_b++; rise_prev_b = rise_last_b; rise_last_b = $time; end

  // Scoreboard monitor, instance A.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (prev_va) begin
        checks++;
        assert (bus_a.sample_valid === 1'b0) else begin failures++; $error("FAIL valid_pulse_a: observed=%b expected=0", bus_a.sample_valid); end
      end
      if (bus_a.sample_valid === 1'b1) begin
        checks++;
        assert (qa.size() != 0) else begin failures++; $error("FAIL unexpected_valid_a: observed pending=0 expected >0"); end
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          checks++;
          assert ({bus_a.sample_ch0, bus_a.sample_ch1} === {ea.c0, ea.c1}) else begin failures++;
            $error("FAIL data_a: observed=%h/%h expected=%h/%h", bus_a.sample_ch0, bus_a.sample_ch1, ea.c0, ea.c1); end
          if (ea.cyc >= 0) begin
            checks++;
            assert (cyc === ea.cyc) else begin failures++; $error("FAIL latency_a: observed cycle=%0d expected=%0d", cyc, ea.cyc); end
          end
        end
      end
    end
    prev_va = (reset === 1'b0) && (bus_a.sample_valid === 1'b1);
  end

  // Scoreboard monitor, instance B.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (prev_vb) begin
        checks++;
        assert (bus_b.sample_valid === 1'b0) else begin failures++; $error("FAIL valid_pulse_b: observed=%b expected=0", bus_b.sample_valid); end
      end
      if (bus_b.sample_valid === 1'b1) begin
        checks++;
        assert (qb.size() != 0) else begin failures++; $error("FAIL unexpected_valid_b: observed pending=0 expected >0"); end
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          checks++;
          assert ({bus_b.sample_ch0, bus_b.sample_ch1} === {eb.c0, eb.c1}) else begin failures++;
            $error("FAIL data_b: observed=%h/%h expected=%h/%h", bus_b.sample_ch0, bus_b.sample_ch1, eb.c0, eb.c1); end
          if (eb.cyc >= 0) begin
            checks++;
            assert (cyc === eb.cyc) else begin failures++; $error("FAIL latency_b: observed cycle=%0d expected=%0d", cyc, eb.cyc); end
          end
        end
      end
    end
    prev_vb = (reset === 1'b0) && (bus_b.sample_valid === 1'b1);
  end

  // Called at a negedge; lat < 0 means the latency is not checked.
  task automatic start_a(input logic [13:0] c0, input logic [13:0] c1, input logic ign, input int lat);
    exp_t e;
    frm_a = mk_frame(c0, c1, ign);
    e.c0 = c0; e.c1 = c1; e.cyc = (lat < 0) ? -1 : cyc + 1 + lat;
    qa.push_back(e);
    bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
  endtask

  task automatic start_b(input logic [13:0] c0, input logic [13:0] c1, input logic ign, input int lat);
    exp_t e;
    frm_b = mk_frame(c0, c1, ign);
    e.c0 = c0; e.c1 = c1; e.cyc = (lat < 0) ? -1 : cyc + 1 + lat;
    qb.push_back(e);
    bus_b.start = 1'b1; @(negedge clk); bus_b.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    assert (qa.size() == 0 && qb.size() == 0) else begin failures++;
      $error("FAIL %s: observed pending=%0d expected=0", tag, qa.size() + qb.size()); end
  endtask

  task automatic check_a(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin failures++; $error("FAIL %s: observed=%h expected=%h", tag, obs, exp); end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.amp_cs_n = 1'b1; bus_a.spimiso = 1'b0;
    bus_b.start = 1'b0; bus_b.amp_cs_n = 1'b1; bus_b.spimiso = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_a("reset_a", {bus_a.spisck, bus_a.ad_conv, bus_a.sample_ch0, bus_a.sample_ch1,
                        bus_a.sample_valid, bus_a.busy, bus_a.overrun}, 32'd0);
    check_a("reset_b", {bus_b.spisck, bus_b.ad_conv, bus_b.sample_ch0, bus_b.sample_ch1,
                        bus_b.sample_valid, bus_b.busy, bus_b.overrun}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame at defaults.
    rises_a = 0; conv_hi_a = 0;
    start_a(14'h1FFF, 14'h2000, 1'b0, 70);
    check_a("busy_after_start", {31'd0, bus_a.busy}, 32'd1);
    wait_drain(200, "drain_basic");
    check_a("sck_rises_a", rises_a, 32'd34);
    check_a("conv_cycles_a", conv_hi_a, 32'd1);
    repeat (3) @(negedge clk);
    check_a("hold_ch0", {18'd0, bus_a.sample_ch0}, {18'd0, 14'h1FFF});

    // Bus owned by the preamp around the request.
    bus_a.amp_cs_n = 1'b0;
    repeat (5) @(negedge clk);
    start_a(14'h2AAA, 14'h1555, 1'b0, -1);
    for (int i = 0; i < 14; i++) begin
      check_a("wait_bus_busy_noconv", {30'd0, bus_a.busy, bus_a.ad_conv}, 32'd2);
      @(negedge clk);
    end
    bus_a.amp_cs_n = 1'b1;
    wait_drain(200, "drain_wait_bus");

    // Slow instance, with the preamp grabbing chip select mid-frame.
    rises_b = 0;
    start_b(14'h0001, 14'h3FFF, 1'b0, 209);
    repeat (30) @(negedge clk);
    bus_b.amp_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    bus_b.amp_cs_n = 1'b1;
    wait_drain(400, "drain_slow");
    check_a("sck_rises_b", rises_b, 32'd34);
    check_a("sck_period_b", 32'(rise_last_b - rise_prev_b), 32'd60);

    // Ones on every ignored bit with zero samples.
    start_a(14'h0000, 14'h0000, 1'b1, 70);
    wait_drain(200, "drain_ignored");

    // Start in the sample_valid cycle is accepted.
    start_a(14'h0ABC, 14'h3123, 1'b1, 70);
    begin
      int n;
      n = 0;
      while (bus_a.sample_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    end
    check_a("b2b_valid_seen", {31'd0, bus_a.sample_valid}, 32'd1);
    start_a(14'h1234, 14'h0F0F, 1'b0, 70);
    wait_drain(200, "drain_b2b");

    // Reset in the middle of SHIFT.
    start_a(14'h3000, 14'h0003, 1'b0, 70);
    repeat (22) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_a("midframe_reset", {bus_a.spisck, bus_a.ad_conv, bus_a.sample_ch0, bus_a.sample_ch1,
                               bus_a.sample_valid, bus_a.busy, bus_a.overrun}, 32'd0);
    qa.delete();
    reset = 1'b0;
    repeat (90) @(negedge clk);
    check_a("no_frame_after_reset", {31'd0, bus_a.busy}, 32'd0);
    start_a(14'h0F0F, 14'h30F0, 1'b0, 70);
    wait_drain(200, "drain_after_reset");

    // Second request while busy: one frame only, overrun per build.
    start_a(14'h1111, 14'h2222, 1'b0, 70);
    repeat (4) @(negedge clk);
    bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
    check_a("overrun_set", {31'd0, bus_a.overrun}, {31'd0, EXP_OVR});
    wait_drain(200, "drain_overrun");
    repeat (100) @(negedge clk);
    check_a("overrun_sticky", {31'd0, bus_a.overrun}, {31'd0, EXP_OVR});
    reset = 1'b1;
    @(negedge clk);
    check_a("overrun_cleared", {31'd0, bus_a.overrun}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
